datapath_controller: RTL

- Multi-cycle FSM that sequences the ARM32 datapath (register file, A/B/S operand regs, shifter, ALU, out1/out2 and status1/status2 pipeline regs) through FETCH, FETCH_WAIT, DECODE, EXECUTE, MEMORY, MEMORY_WAIT and WRITE_BACK.
- Decodes the fetched 32-bit instruction, evaluates its condition field against NZCV, and drives every datapath control input, plus the PC, instruction-register and RAM strobes.
- Supported classes: data-processing (immediate, register-immediate-shift, register-register-shift), LDR/STR immediate offset, and B.

---
 rtl/arm_pkg.sv | 62 ++++++
 rtl/cond_check.sv | 35 +++
 rtl/datapath_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM32 controller types, encodings and helpers
package arm_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_MEMORY_WAIT,
    S_WRITE_BACK
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_EOR = 3'b100,
    ALU_MOV = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_t;

  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_t;

  localparam logic [3:0] OPC_AND = 4'b0000;
  localparam logic [3:0] OPC_EOR = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_ADD = 4'b0100;
  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_ORR = 4'b1100;
  localparam logic [3:0] OPC_MOV = 4'b1101;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_ORR: r = a | b;
      ALU_EOR: r = a ^ b;
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - ARM condition-field evaluation against NZCV
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      C_EQ:    pass = w_z;
      C_NE:    pass = !w_z;
      C_CS:    pass = w_c;
      C_CC:    pass = !w_c;
      C_MI:    pass = w_n;
      C_PL:    pass = !w_n;
      C_VS:    pass = w_v;
      C_VC:    pass = !w_v;
      C_HI:    pass = w_c && !w_z;
      C_LS:    pass = !w_c || w_z;
      C_GE:    pass = (w_n == w_v);
      C_LT:    pass = (w_n != w_v);
      C_GT:    pass = !w_z && (w_n == w_v);
      C_LE:    pass = w_z || (w_n != w_v);
      C_AL:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - multi-cycle ARM32 datapath sequencer and decoder
module datapath_controller
  import arm_pkg::*;
#(
  parameter int PC_W = 32
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [31:0]     status,
  output logic [PC_W-1:0] pc,
  output logic            ram_w_en,
  output logic [3:0]      A_addr,
  output logic [3:0]      B_addr,
  output logic [3:0]      shift_addr,
  output logic            en_A,
  output logic            en_B,
  output logic            en_S,
  output logic            en_out1,
  output logic            en_out2,
  output logic            en_status1,
  output logic            en_status2,
  output logic [1:0]      shift_op,
  output logic            sel_shift,
  output logic [31:0]     shift_imme,
  output logic            sel_A,
  output logic            sel_B,
  output logic            sel_post_shift,
  output logic [31:0]     imme_data,
  output logic [2:0]      ALU_op,
  output logic [3:0]      w_addr1,
  output logic [3:0]      w_addr2,
  output logic            w_en1,
  output logic            w_en2,
  output logic            sel_w_data,
  output logic [1:0]      sel_A_in,
  output logic [1:0]      sel_B_in,
  output logic [1:0]      sel_shift_in,
  output logic            illegal
);

  state_t            r_state, w_next;
  logic [PC_W-1:0]   r_pc, r_target, w_pc_next;
  logic [31:0]       r_ir;
  logic              w_pc_load;

  logic [3:0]  w_rn, w_rd, w_rm, w_rs, w_opc;
  logic        w_sbit, w_ibit, w_load, w_pass;
  logic        w_is_dp, w_dp_ok, w_is_mem, w_is_br, w_no_wr, w_rd_pc, w_pc_ok, w_legal;
  logic        w_redirect;
  alu_op_t     w_alu_op;
  logic [31:0] w_op2_imm, w_pc8, w_br_off, w_br_tgt, w_alu_res;
  logic        w_unused;

  assign w_rn   = r_ir[19:16];
  assign w_rd   = r_ir[15:12];
  assign w_rs   = r_ir[11:8];
  assign w_rm   = r_ir[3:0];
  assign w_opc  = r_ir[24:21];
  assign w_sbit = r_ir[20];
  assign w_ibit = r_ir[25];
  assign w_load = r_ir[20];

  assign w_is_dp  = (r_ir[27:26] == 2'b00);
  assign w_no_wr  = (w_opc inside {OPC_CMP, OPC_TST});
  // bit7 & bit4 set in the register-shift form is the multiply/extension space
  assign w_dp_ok  = (w_opc inside {OPC_AND, OPC_EOR, OPC_SUB, OPC_ADD, OPC_TST, OPC_CMP,
                                   OPC_ORR, OPC_MOV})
                 && (!w_no_wr || w_sbit) && (w_ibit || !r_ir[4] || !r_ir[7]);
  assign w_is_mem = (r_ir[27:26] == 2'b01) && !r_ir[25] && r_ir[24] && !r_ir[22]
                 && !r_ir[21] && (w_rd != 4'd15);
  assign w_is_br  = (r_ir[27:24] == 4'b1010);

  // r15 destinations are only resolvable here when the result needs no register operand
  assign w_rd_pc  = w_is_dp && !w_no_wr && (w_rd == 4'd15);
  assign w_pc_ok  = w_ibit && ((w_opc == OPC_MOV) || (w_rn == 4'd15));
  assign w_legal  = (w_is_dp && w_dp_ok && (!w_rd_pc || w_pc_ok)) || w_is_mem || w_is_br;
  assign w_redirect = w_is_br || w_rd_pc;

  assign w_op2_imm = ror32({24'd0, r_ir[7:0]}, {r_ir[11:8], 1'b0});
  assign w_pc8     = 32'(r_pc) + 32'd8;
  assign w_br_off  = {{6{r_ir[23]}}, r_ir[23:0], 2'b00};
  assign w_br_tgt  = w_pc8 + w_br_off;
  assign w_alu_res = alu_eval(w_alu_op, (w_rn == 4'd15) ? w_pc8 : 32'd0, w_op2_imm);

  assign pc           = r_pc;
  assign w_addr2      = 4'd0;
  assign w_en2        = 1'b0;
  assign sel_A_in     = 2'b00;
  assign sel_B_in     = 2'b00;
  assign sel_shift_in = 2'b00;
  assign w_unused     = ^status[27:0];

  cond_check u_cond (
    .cond (r_ir[31:28]),
    .nzcv (status[31:28]),
    .pass (w_pass)
  );

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_opc)
      OPC_AND, OPC_TST: w_alu_op = ALU_AND;
      OPC_EOR:          w_alu_op = ALU_EOR;
      OPC_SUB, OPC_CMP: w_alu_op = ALU_SUB;
      OPC_ORR:          w_alu_op = ALU_ORR;
      OPC_MOV:          w_alu_op = ALU_MOV;
      default:          w_alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH_WAIT) r_ir <= instr;
      if (r_state == S_EXECUTE)
        r_target <= w_is_br ? PC_W'(w_br_tgt) : PC_W'(w_alu_res);
      if (w_pc_load) r_pc <= w_pc_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_pc_load      = 1'b0;
    w_pc_next      = r_pc + PC_W'(4);
    ram_w_en       = 1'b0;
    A_addr         = 4'd0;
    B_addr         = 4'd0;
    shift_addr     = 4'd0;
    en_A           = 1'b0;
    en_B           = 1'b0;
    en_S           = 1'b0;
    en_out1        = 1'b0;
    en_out2        = 1'b0;
    en_status1     = 1'b0;
    en_status2     = 1'b0;
    shift_op       = SH_LSL;
    sel_shift      = 1'b0;
    shift_imme     = 32'd0;
    sel_A          = 1'b0;
    sel_B          = 1'b0;
    sel_post_shift = 1'b0;
    imme_data      = 32'd0;
    ALU_op         = ALU_ADD;
    w_addr1        = 4'd0;
    w_en1          = 1'b0;
    sel_w_data     = 1'b0;
    illegal        = 1'b0;
    case (r_state)
      S_FETCH:      w_next = S_FETCH_WAIT;
      S_FETCH_WAIT: w_next = S_DECODE;
      S_DECODE: begin
        en_A       = 1'b1;
        en_B       = 1'b1;
        en_S       = 1'b1;
        A_addr     = w_rn;
        // stores need Rd on the B port as write data; the Rm field is part of imm12
        B_addr     = w_is_mem ? w_rd : w_rm;
        shift_addr = w_rs;
        if (!w_pass || !w_legal) begin
          illegal   = w_pass;
          w_pc_load = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE, S_MEMORY: begin
        if (w_is_mem) begin
          ALU_op    = r_ir[23] ? ALU_ADD : ALU_SUB;
          sel_B     = 1'b1;
          imme_data = {20'd0, r_ir[11:0]};
        end else if (w_is_br) begin
          ALU_op    = ALU_MOV;
          sel_A     = 1'b1;
          sel_B     = 1'b1;
          imme_data = w_br_tgt;
        end else begin
          ALU_op         = w_alu_op;
          sel_A          = (w_opc == OPC_MOV);
          sel_B          = w_ibit;
          sel_post_shift = !w_ibit;
          imme_data      = w_ibit ? w_op2_imm : 32'd0;
          shift_op       = w_ibit ? SH_LSL : r_ir[6:5];
          sel_shift      = !w_ibit && r_ir[4];
          shift_imme     = (!w_ibit && !r_ir[4]) ? {27'd0, r_ir[11:7]} : 32'd0;
          en_status1     = w_sbit && (r_state == S_EXECUTE);
        end
        if (r_state == S_EXECUTE) begin
          en_out1 = 1'b1;
          w_next  = w_is_mem ? S_MEMORY : S_WRITE_BACK;
        end else begin
          en_out2  = 1'b1;
          ram_w_en = !w_load;
          w_next   = S_MEMORY_WAIT;
        end
      end
      S_MEMORY_WAIT: begin
        if (w_load) begin
          w_next = S_WRITE_BACK;
        end else begin
          w_pc_load = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_WRITE_BACK: begin
        en_out2    = 1'b1;
        en_status2 = 1'b1;
        if (!w_is_br) begin
          w_en1      = w_is_mem || !w_no_wr;
          w_addr1    = w_rd;
          sel_w_data = w_is_mem;
        end
        w_pc_load = 1'b1;
        if (w_redirect) w_pc_next = r_target;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule
